// File: rtl/stage4_memory.sv
// rtl/stage4_memory.sv - memory-access stage: load/store over req/gnt/rvalid bus with stall, timeout and flush
module stage4_memory #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic            rd_mem_i,
    input  logic            wr_mem_i,
    input  logic [1:0]      size_i,
    input  logic            ld_unsigned_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            mem_stall_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            flushed_q, flushed_d;

    logic            mem_op;
    logic            is_load;
    logic            sz_byte, sz_half;
    logic            misaligned;
    logic [1:0]      off;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_val;
    logic            req_c, stall_c, mis_c, err_c;
    logic [XLEN-1:0] rdata_c;

    // Stage inputs are held by the stall, so the bus fields are driven straight from them.
    always_comb begin
        off        = alu_result_i[1:0];
        mem_op     = (rd_mem_i | wr_mem_i) & ~flush_i;
        is_load    = rd_mem_i & ~wr_mem_i;
        sz_byte    = (size_i == 2'b00);
        sz_half    = (size_i == 2'b01);
        misaligned = (sz_half & off[0]) | (size_i[1] & (off != 2'b00));

        dmem_we_o    = wr_mem_i;
        dmem_addr_o  = alu_result_i;
        dmem_wstrb_o = 4'b0000;
        dmem_wdata_o = write_data_i;
        if (sz_byte) begin
            dmem_wdata_o = {4{write_data_i[7:0]}};
        end else if (sz_half) begin
            dmem_wdata_o = {2{write_data_i[15:0]}};
        end
        if (wr_mem_i) begin
            if (sz_byte) begin
                dmem_wstrb_o = 4'b0001 << off;
            end else if (sz_half) begin
                dmem_wstrb_o = 4'b0011 << off;
            end else begin
                dmem_wstrb_o = 4'b1111;
            end
        end

        lane   = dmem_rdata_i >> {off, 3'b000};
        ld_val = dmem_rdata_i;
        if (sz_byte) begin
            ld_val = {{24{~ld_unsigned_i & lane[7]}}, lane[7:0]};
        end else if (sz_half) begin
            ld_val = {{16{~ld_unsigned_i & lane[15]}}, lane[15:0]};
        end
    end

    always_comb begin
        state_d   = state_q;
        flushed_d = flushed_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        mis_c     = 1'b0;
        err_c     = 1'b0;
        rdata_c   = '0;
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (mem_op) begin
                    if (misaligned) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c   = 1'b1;
                        stall_c = 1'b1;
                        state_d = dmem_gnt_i ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (dmem_gnt_i) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                // A granted access must drain even when flushed; its data is then dropped.
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    if (is_load && !(flush_i || flushed_q)) begin
                        rdata_c = ld_val;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (flush_i) begin
                        flushed_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs are qualified by reset so nothing leaks onto the bus while held in reset.
    assign dmem_req_o  = req_c & rst_ni;
    assign mem_stall_o = stall_c & rst_ni;
    assign misalign_o  = mis_c & rst_ni;
    assign bus_err_o   = err_c & rst_ni;
    assign mem_rdata_o = rst_ni ? rdata_c : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flushed_q <= flushed_d;
        end
    end

endmodule

// File: tb/tb_stage4_memory.sv
// tb/tb_stage4_memory.sv - table-driven and sequence checks of stage4_memory with a load-data scoreboard
module tb_stage4_memory;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] alu_result_i;
    logic [31:0] write_data_i;
    logic        rd_mem_i;
    logic        wr_mem_i;
    logic [1:0]  size_i;
    logic        ld_unsigned_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    stage4_memory #(.XLEN(32), .TIMEOUT(255)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .alu_result_i  (alu_result_i),
        .write_data_i  (write_data_i),
        .rd_mem_i      (rd_mem_i),
        .wr_mem_i      (wr_mem_i),
        .size_i        (size_i),
        .ld_unsigned_i (ld_unsigned_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wstrb_o  (dmem_wstrb_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_stall_o   (mem_stall_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        exp_mis;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 15;
    vec_t        tbl [NV];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got completion 0x%08h expected none (scoreboard empty)", nm, mem_rdata_o);
        end else begin
            chk(nm, mem_rdata_o, exp_q.pop_front());
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input logic mis, input logic req,
                                input logic [3:0] wstrb, input logic [31:0] wdata, input logic [31:0] rdo);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
        v.rdata = rdata; v.exp_mis = mis; v.exp_req = req; v.exp_wstrb = wstrb;
        v.exp_wdata = wdata; v.exp_rd = rdo;
        return v;
    endfunction

    task automatic idle_inputs();
        flush_i = 1'b0; rd_mem_i = 1'b0; wr_mem_i = 1'b0; size_i = 2'b10; ld_unsigned_i = 1'b0;
        alu_result_i = 32'h0; write_data_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
        rd_mem_i = rd; wr_mem_i = wr; size_i = sz; ld_unsigned_i = uns;
        alu_result_i = addr; write_data_i = wd;
    endtask

    initial begin
        vec_t v;
        int   err_at;
        logic req_held;

        tbl[0]  = mk("lw_100",   1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b0000, 32'h0,        32'hDEADBEEF);
        tbl[1]  = mk("lb_103",   1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80112233, 0, 1, 4'b0000, 32'h0,        32'hFFFFFF80);
        tbl[2]  = mk("lbu_103",  1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80112233, 0, 1, 4'b0000, 32'h0,        32'h00000080);
        tbl[3]  = mk("lhu_102",  1, 0, 2'b01, 1, 32'h102, 32'h0,        32'h80112233, 0, 1, 4'b0000, 32'h0,        32'h00008011);
        tbl[4]  = mk("lh_102",   1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80112233, 0, 1, 4'b0000, 32'h0,        32'hFFFF8011);
        tbl[5]  = mk("lb_100",   1, 0, 2'b00, 0, 32'h100, 32'h0,        32'h80112233, 0, 1, 4'b0000, 32'h0,        32'h00000033);
        tbl[6]  = mk("sb_101",   0, 1, 2'b00, 0, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 0, 1, 4'b0010, 32'hABABABAB, 32'h0);
        tbl[7]  = mk("sh_102",   0, 1, 2'b01, 0, 32'h102, 32'h00001234, 32'hFFFFFFFF, 0, 1, 4'b1100, 32'h12341234, 32'h0);
        tbl[8]  = mk("sw_104",   0, 1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0);
        tbl[9]  = mk("lw_102",   1, 0, 2'b10, 0, 32'h102, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        32'h0);
        tbl[10] = mk("lh_101",   1, 0, 2'b01, 0, 32'h101, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        32'h0);
        tbl[11] = mk("ldst_108", 1, 1, 2'b10, 0, 32'h108, 32'h55AA55AA, 32'hFFFFFFFF, 0, 1, 4'b1111, 32'h55AA55AA, 32'h0);
        tbl[12] = mk("lw11_10c", 1, 0, 2'b11, 0, 32'h10C, 32'h0,        32'h12345678, 0, 1, 4'b0000, 32'h0,        32'h12345678);
        tbl[13] = mk("nonmem",   0, 0, 2'b10, 0, 32'h104, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[14] = mk("sh_103",   0, 1, 2'b01, 0, 32'h103, 32'h0000BEEF, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0);

        // Held in reset with a load presented: everything must stay quiet.
        idle_inputs();
        rst_ni = 1'b0;
        drive_op(1, 0, 2'b10, 0, 32'h100, 32'h0);
        #3;
        chk("rst_req",     dmem_req_o,  0);
        chk("rst_stall",   mem_stall_o, 0);
        chk("rst_mis",     misalign_o,  0);
        chk("rst_err",     bus_err_o,   0);
        chk("rst_rdata",   mem_rdata_o, 0);
        @(posedge clk); #1;
        idle_inputs();
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            @(posedge clk); #1;
            drive_op(v.rd, v.wr, v.sz, v.uns, v.addr, v.wd);
            dmem_gnt_i = v.exp_req;
            dmem_rvalid_i = 1'b0;
            #1;
            chk({v.name, "_mis"},   misalign_o,  v.exp_mis);
            chk({v.name, "_req"},   dmem_req_o,  v.exp_req);
            chk({v.name, "_stall"}, mem_stall_o, v.exp_req);
            if (v.exp_req) begin
                chk({v.name, "_addr"},  dmem_addr_o,  v.addr);
                chk({v.name, "_we"},    dmem_we_o,    v.wr);
                chk({v.name, "_wstrb"}, dmem_wstrb_o, v.exp_wstrb);
                if (v.wr) chk({v.name, "_wdata"}, dmem_wdata_o, v.exp_wdata);
                exp_q.push_back(v.exp_rd);
                @(posedge clk); #1;
                dmem_gnt_i = 1'b0;
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i = v.rdata;
                #1;
                chk({v.name, "_resp_req"},   dmem_req_o,  0);
                chk({v.name, "_resp_stall"}, mem_stall_o, 0);
                pop_chk({v.name, "_rdata"});
            end else begin
                chk({v.name, "_rdata"}, mem_rdata_o, 0);
            end
            @(posedge clk); #1;
            idle_inputs();
        end

        // Grant withheld three cycles: request fields stay put, stall runs through the response.
        @(posedge clk); #1;
        drive_op(0, 1, 2'b10, 0, 32'h200, 32'h11223344);
        exp_q.push_back(32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wait_req",   dmem_req_o,   1);
            chk("wait_stall", mem_stall_o,  1);
            chk("wait_addr",  dmem_addr_o,  32'h200);
            chk("wait_wdata", dmem_wdata_o, 32'h11223344);
            @(posedge clk); #1;
        end
        dmem_gnt_i = 1'b1;
        #1;
        chk("wait_gnt_req", dmem_req_o, 1);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        #1;
        chk("wait_resp_req",   dmem_req_o,  0);
        chk("wait_resp_stall", mem_stall_o, 1);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b1;
        #1;
        chk("wait_done_stall", mem_stall_o, 0);
        pop_chk("wait_done_rdata");
        @(posedge clk); #1;
        idle_inputs();

        // No grant at all: error pulse once the counter reaches 255 in REQ.
        @(posedge clk); #1;
        drive_op(1, 0, 2'b10, 0, 32'h300, 32'h0);
        err_at = -1;
        req_held = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #2;
            if (bus_err_o) begin
                err_at = c;
                break;
            end
            if (!dmem_req_o || !mem_stall_o) req_held = 1'b0;
        end
        chk("to_req_held",  req_held, 1);
        chk("to_err_cycle", err_at, 256);
        chk("to_req_drop",  dmem_req_o,  0);
        chk("to_stall_rel", mem_stall_o, 0);
        chk("to_rdata",     mem_rdata_o, 0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("to_err_pulse", bus_err_o, 0);

        // Flush while waiting for grant: request withdrawn, stage returns to IDLE.
        @(posedge clk); #1;
        drive_op(1, 0, 2'b10, 0, 32'h400, 32'h0);
        #1;
        chk("fr_issue_req", dmem_req_o, 1);
        @(posedge clk); #1;
        flush_i = 1'b1;
        #1;
        chk("fr_req",   dmem_req_o,  0);
        chk("fr_stall", mem_stall_o, 0);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b1;
        #1;
        chk("fr_next_req",   dmem_req_o,  0);
        chk("fr_next_stall", mem_stall_o, 0);
        @(posedge clk); #1;
        idle_inputs();

        // Flush after grant: stall until rvalid, then data discarded.
        @(posedge clk); #1;
        drive_op(1, 0, 2'b10, 0, 32'h500, 32'h0);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fresp_stall", mem_stall_o, 1);
        chk("fresp_req",   dmem_req_o,  0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("fresp_done_stall", mem_stall_o, 0);
        chk("fresp_discard",    mem_rdata_o, 0);
        @(posedge clk); #1;
        idle_inputs();

        // Asynchronous reset while awaiting the response.
        @(posedge clk); #1;
        drive_op(1, 0, 2'b10, 0, 32'h600, 32'h0);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        #1;
        chk("ar_pre_stall", mem_stall_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("ar_req",   dmem_req_o,  0);
        chk("ar_stall", mem_stall_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        rd_mem_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h13572468;
        #1;
        chk("ar_stray_stall", mem_stall_o, 0);
        chk("ar_stray_rdata", mem_rdata_o, 0);
        @(posedge clk); #1;
        idle_inputs();

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
